// File: rtl/signed_div_pkg.sv
// Shared types and constants for the signed divide sequencer.
// Status bits are packed into one vector and fanned out at the top.
package signed_div_pkg;

    localparam int WIDTH = 128;
    localparam int DIV_W = 128;

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam int ST_DBZ = 0;
    localparam int ST_OVF = 1;
    localparam int ST_TMO = 2;
    localparam int ST_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIXUP,
        S_OUTPUT
    } state_t;

    function automatic logic neg_of(input logic [WIDTH-1:0] v, input logic sgn);
        return sgn & v[WIDTH-1];
    endfunction

endpackage

// File: rtl/signed_div_sequencer_negate.sv
// Conditional two's-complement negate, purely combinational.
module twos_negate
    import signed_div_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/signed_div_sequencer.sv
// Operand screening, divider launch/wait and sign fix-up around an
// external 128-bit unsigned sequential divider.
module signed_div_sequencer #(
    parameter int WIDTH   = signed_div_pkg::WIDTH,
    parameter int TIMEOUT = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [127:0]     div_dividend,
    output logic [127:0]     div_divisor,
    output logic             div_reset_n,
    input  logic             div_done,
    input  logic [127:0]     div_quotient,
    input  logic [127:0]     div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             timeout
);
    import signed_div_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic armed;
    logic accept;
    logic zero_div;
    logic ovf_hit;
    logic wait_last;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] raw_q, raw_r;
    logic [WIDTH-1:0] fix_q, fix_r;
    logic q_neg, r_neg;
    logic [CW-1:0] cnt;
    logic [ST_W-1:0] status;

    twos_negate #(.W(WIDTH)) u_abs_a (
        .neg (neg_of(dividend, is_signed)),
        .a   (dividend),
        .y   (abs_a)
    );

    twos_negate #(.W(WIDTH)) u_abs_b (
        .neg (neg_of(divisor, is_signed)),
        .a   (divisor),
        .y   (abs_b)
    );

    twos_negate #(.W(WIDTH)) u_fix_q (
        .neg (q_neg),
        .a   (raw_q),
        .y   (fix_q)
    );

    twos_negate #(.W(WIDTH)) u_fix_r (
        .neg (r_neg),
        .a   (raw_r),
        .y   (fix_r)
    );

    // armed keeps in_ready low for the cycle(s) reset is held
    assign in_ready    = armed && (state == S_IDLE);
    assign out_valid   = (state == S_OUTPUT);
    assign div_reset_n = (state == S_WAIT);

    assign accept    = in_valid && in_ready;
    assign zero_div  = (divisor == '0);
    assign ovf_hit   = is_signed && (dividend == SMIN) && (divisor == '1);
    assign wait_last = (cnt == LAST);

    assign div_by_zero = status[ST_DBZ];
    assign overflow    = status[ST_OVF];
    assign timeout     = status[ST_TMO];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (zero_div || ovf_hit) state_next = S_OUTPUT;
                    else                     state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (div_done)       state_next = S_FIXUP;
                else if (wait_last) state_next = S_OUTPUT;
            end
            S_FIXUP: state_next = S_OUTPUT;
            S_OUTPUT: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            raw_q        <= '0;
            raw_r        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            cnt          <= '0;
            quotient     <= '0;
            remainder    <= '0;
            status       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_dividend <= DIV_W'(abs_a);
                        div_divisor  <= DIV_W'(abs_b);
                        q_neg <= neg_of(dividend ^ divisor, is_signed);
                        r_neg <= neg_of(dividend, is_signed);
                        cnt   <= '0;
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            status    <= '0;
                            status[ST_DBZ] <= 1'b1;
                        end else if (ovf_hit) begin
                            quotient  <= SMIN;
                            remainder <= '0;
                            status    <= '0;
                            status[ST_OVF] <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // done beats a timeout that lands on the same cycle
                    if (div_done) begin
                        raw_q <= WIDTH'(div_quotient);
                        raw_r <= WIDTH'(div_remainder);
                    end else if (wait_last) begin
                        quotient  <= '0;
                        remainder <= '0;
                        status    <= '0;
                        status[ST_TMO] <= 1'b1;
                    end
                end
                S_FIXUP: begin
                    quotient  <= fix_q;
                    remainder <= fix_r;
                    status    <= '0;
                end
                S_OUTPUT: begin
                    if (out_ready) status <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Randomised bench: signed/unsigned division checked against plain
// SystemVerilog arithmetic, with a behavioural sequential divider.
module tb_signed_div_sequencer;

    localparam int TMO = 300;
    localparam logic [127:0] MINV = {1'b1, 127'b0};

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] dividend;
    logic [127:0] divisor;
    logic         is_signed;
    logic [127:0] div_dividend;
    logic [127:0] div_divisor;
    logic         div_reset_n;
    logic         div_done;
    logic [127:0] div_quotient;
    logic [127:0] div_remainder;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] quotient;
    logic [127:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    logic         timeout;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt  = 0;
    int m_lat  = 1;
    logic m_stall = 1'b0;

    signed_div_sequencer #(.WIDTH(128), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .is_signed    (is_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_reset_n  (div_reset_n),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural divider: result appears m_lat cycles after release
    always @(posedge clk) begin
        if (!div_reset_n) begin
            m_cnt    <= 0;
            div_done <= 1'b0;
        end else if (!m_stall) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_lat) begin
                div_done      <= 1'b1;
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_div(input logic [127:0] a, input logic [127:0] b,
                           input logic s, output logic [127:0] q,
                           output logic [127:0] r, output logic dbz,
                           output logic ovf);
        logic signed [127:0] sa, sb;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
            dbz = 1'b1;
        end else if (s && a == MINV && b == '1) begin
            q = MINV;
            r = '0;
            ovf = 1'b1;
        end else if (s) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                          input logic s, input int hold, input int lat_div,
                          input logic stall);
        logic [127:0] eq, er;
        logic edbz, eovf, etmo, short_op, rel;
        int k, lat, low, exp_lat;
        ref_div(a, b, s, eq, er, edbz, eovf);
        short_op = edbz | eovf;
        etmo = stall & ~short_op;
        if (etmo) begin
            eq = '0;
            er = '0;
        end
        exp_lat = short_op ? 1 : (stall ? TMO + 2 : lat_div + 4);
        m_lat = lat_div;
        m_stall = stall;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        dividend = a;
        divisor = b;
        is_signed = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        low = 0;
        rel = 1'b0;
        while (!out_valid && lat < TMO + 50) begin
            if (!rel) begin
                if (div_reset_n) rel = 1'b1;
                else low++;
            end
            check("ready_busy", in_ready, 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid", out_valid, 1'b1);
        check("latency", lat, exp_lat);
        check("released", rel, !short_op);
        if (!short_op) check("launch_low", low, 1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edbz);
        check("overflow", overflow, eovf);
        check("timeout", timeout, etmo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_ready", in_ready, 1'b0);
            check("hold_q", quotient, eq);
            check("hold_r", remainder, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_stall = 1'b0;
        check("post_valid", out_valid, 1'b0);
        check("post_ready", in_ready, 1'b1);
        check("post_status", {div_by_zero, overflow, timeout}, 3'b000);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] a, b;
        int sel;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_div_reset_n", div_reset_n, 1'b0);
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);
        check("rst_status", {div_by_zero, overflow, timeout}, 3'b000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1'b1);

        run_op(128'd100, 128'd7, 1'b0, 0, 5, 1'b0);
        run_op(-128'sd7, 128'd2, 1'b1, 0, 3, 1'b0);
        run_op(128'd5, 128'd0, 1'b1, 0, 3, 1'b0);
        run_op(MINV, '1, 1'b1, 0, 3, 1'b0);
        run_op(MINV, '1, 1'b0, 0, 2, 1'b0);
        run_op(-128'sd1000, -128'sd33, 1'b1, 10, 1, 1'b0);
        run_op(rnd128(), 128'd9, 1'b1, 0, 1, 1'b1);
        run_op(128'd77, 128'd8, 1'b0, 0, TMO - 1, 1'b0);

        // abort mid-WAIT with a synchronous reset pulse
        m_stall = 1'b1;
        dividend = 128'd50;
        divisor = 128'd3;
        is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_wait_rel", div_reset_n, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_stall = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_div_rst", div_reset_n, 1'b0);
        check("abort_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("abort_ready_up", in_ready, 1'b1);
        check("abort_valid2", out_valid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            a = rnd128() >> $urandom_range(0, 127);
            b = rnd128() >> $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            if (sel == 0) b = '0;
            if (sel == 1) begin
                a = MINV;
                b = '1;
            end
            run_op(a, b, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(1, 12), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
